// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed active-low seven-segment bus: decodes the lit
// position, debounces it over consecutive scans and rebuilds the 0-19 readout.
module seg_scan_decoder #(
  parameter int NUM_DIGITS   = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [4:0]              num_out,
  output logic                    num_valid,
  output logic                    update,
  output logic                    err_an,
  output logic                    err_seg
);

  localparam logic [2:0] STABLE = 3'(STABLE_SCANS);

  // Returns {valid, code}; blank decodes to code F.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h7F:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [3:0]              cand_reg [NUM_DIGITS];
  logic [3:0]              cand_next[NUM_DIGITS];
  logic [2:0]              cnt_reg  [NUM_DIGITS];
  logic [2:0]              cnt_next [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
  logic [NUM_DIGITS-1:0]   valid_reg, valid_next;
  logic [4:0]              num_reg, num_next;
  logic                    num_valid_reg, num_valid_next;
  logic                    update_reg, update_next;
  logic                    err_an_reg, err_an_next;
  logic                    err_seg_reg, err_seg_next;

  logic [NUM_DIGITS-1:0]   low;
  logic                    multi_low, one_low;
  logic [4:0]              dec;
  logic [2:0]              cnt_new;
  logic [3:0]              tens, units;
  logic                    num_ok;

  assign low       = ~an;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_low = |(low & (low - NUM_DIGITS'(1)));
  assign one_low   = (|low) && !multi_low;
  assign dec       = decode(seg);

  always_comb begin
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    digits_next  = digits_reg;
    valid_next   = valid_reg;
    update_next  = 1'b0;
    err_an_next  = sample_en && multi_low;
    err_seg_next = 1'b0;
    cnt_new      = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sample_en && one_low && !an[i]) begin
        if (!dec[4]) begin
          err_seg_next = 1'b1;
          cand_next[i] = 4'd0;
          cnt_next[i]  = 3'd0;
        end else begin
          if (dec[3:0] == cand_reg[i]) begin
            cnt_new = (cnt_reg[i] >= STABLE) ? STABLE : cnt_reg[i] + 3'd1;
          end else begin
            cand_next[i] = dec[3:0];
            cnt_new      = 3'd1;
          end
          cnt_next[i] = cnt_new;
          if (cnt_new == STABLE &&
              (!valid_reg[i] || digits_reg[4*i +: 4] != dec[3:0])) begin
            digits_next[4*i +: 4] = dec[3:0];
            valid_next[i]         = 1'b1;
            update_next           = 1'b1;
          end
        end
      end
    end

    // Readout tracks the next committed digits so it lands in the same cycle.
    tens   = digits_next[7:4];
    units  = digits_next[3:0];
    num_ok = (&valid_next[1:0]) && (tens <= 4'd1 || tens == 4'hF) && (units <= 4'd9);
    num_valid_next = num_ok;
    if (!num_ok)
      num_next = 5'd0;
    else if (tens == 4'd1)
      num_next = 5'd10 + {1'b0, units};
    else
      num_next = {1'b0, units};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_reg[i] <= 4'd0;
        cnt_reg[i]  <= 3'd0;
      end
      digits_reg    <= '0;
      valid_reg     <= '0;
      num_reg       <= 5'd0;
      num_valid_reg <= 1'b0;
      update_reg    <= 1'b0;
      err_an_reg    <= 1'b0;
      err_seg_reg   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_reg[i] <= cand_next[i];
        cnt_reg[i]  <= cnt_next[i];
      end
      digits_reg    <= digits_next;
      valid_reg     <= valid_next;
      num_reg       <= num_next;
      num_valid_reg <= num_valid_next;
      update_reg    <= update_next;
      err_an_reg    <= err_an_next;
      err_seg_reg   <= err_seg_next;
    end
  end

  assign digits      = digits_reg;
  assign digit_valid = valid_reg;
  assign num_out     = num_reg;
  assign num_valid   = num_valid_reg;
  assign update      = update_reg;
  assign err_an      = err_an_reg;
  assign err_seg     = err_seg_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Vector table for the directed scenarios, then randomized scans checked
// against a sample-history model of the debounce rules.
module tb_seg_scan_decoder;
  localparam int N = 4;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic [N-1:0]  an = '1;
  logic [6:0]    seg = 7'h7F;
  logic [4*N-1:0] digits;
  logic [N-1:0]  digit_valid;
  logic [4:0]    num_out;
  logic          num_valid, update, err_an, err_seg;

  int errors = 0;
  int checks = 0;

  seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_SCANS(S)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .an(an), .seg(seg),
    .digits(digits), .digit_valid(digit_valid), .num_out(num_out),
    .num_valid(num_valid), .update(update), .err_an(err_an), .err_seg(err_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] dig;
    logic [3:0]  val;
    logic [4:0]  num;
    logic        nv;
    logic        upd;
    logic        ea;
    logic        es;
  } vec_t;

  vec_t vecs[23];

  logic [6:0] pat[11];
  int         hist[N][$];
  logic [15:0] m_dig;
  logic [3:0]  m_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [6:0] s, input logic en);
    an = a;
    seg = s;
    sample_en = en;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic chk_all(input logic [15:0] d, input logic [3:0] v, input logic [4:0] n,
                         input logic nv, input logic u, input logic ea, input logic es);
    chk("digits", 32'(digits), 32'(d));
    chk("digit_valid", 32'(digit_valid), 32'(v));
    chk("num_out", 32'(num_out), 32'(n));
    chk("num_valid", 32'(num_valid), 32'(nv));
    chk("update", 32'(update), 32'(u));
    chk("err_an", 32'(err_an), 32'(ea));
    chk("err_seg", 32'(err_seg), 32'(es));
  endtask

  function automatic int seg_code(input logic [6:0] s);
    for (int k = 0; k < 11; k++)
      if (pat[k] == s) return (k == 10) ? 15 : k;
    return -1;
  endfunction

  // Commit rule: the last S valid samples of a position (no invalid in between) all agree.
  task automatic model_step(input logic [3:0] a, input logic [6:0] s, input logic en,
                            output logic u, output logic ea, output logic es);
    int zeros, idx, c;
    bit same;
    u = 0; ea = 0; es = 0;
    zeros = 0; idx = 0;
    if (!en) return;
    for (int k = 0; k < N; k++) if (!a[k]) begin zeros++; idx = k; end
    if (zeros > 1) begin ea = 1; return; end
    if (zeros == 0) return;
    c = seg_code(s);
    if (c < 0) begin
      es = 1;
      hist[idx].delete();
      return;
    end
    hist[idx].push_back(c);
    if (hist[idx].size() > S) void'(hist[idx].pop_front());
    if (hist[idx].size() == S) begin
      same = 1;
      foreach (hist[idx][k]) if (hist[idx][k] != c) same = 0;
      if (same && (!m_val[idx] || m_dig[4*idx +: 4] != 4'(c))) begin
        m_dig[4*idx +: 4] = 4'(c);
        m_val[idx] = 1'b1;
        u = 1;
      end
    end
  endtask

  task automatic model_num(output logic [4:0] n, output logic nv);
    int t, un;
    t = m_dig[7:4];
    un = m_dig[3:0];
    nv = m_val[0] && m_val[1] && (t <= 1 || t == 15) && un <= 9;
    if (t == 15) t = 0;
    n = nv ? 5'(t * 10 + un) : 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_en = 1'b1;
    an = 4'b1110;
    seg = 7'h40;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sample_en = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    logic en, u, ea, es, nv;
    logic [4:0] n;

    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

    vecs[0]  = '{4'b1110, 7'h12, 16'h0000, 4'b0000, 5'd0,  0, 0, 0, 0};
    vecs[1]  = '{4'b1110, 7'h12, 16'h0005, 4'b0001, 5'd0,  0, 1, 0, 0};
    vecs[2]  = '{4'b1110, 7'h30, 16'h0005, 4'b0001, 5'd0,  0, 0, 0, 0};
    vecs[3]  = '{4'b1101, 7'h79, 16'h0005, 4'b0001, 5'd0,  0, 0, 0, 0};
    vecs[4]  = '{4'b1110, 7'h30, 16'h0003, 4'b0001, 5'd0,  0, 1, 0, 0};
    vecs[5]  = '{4'b1101, 7'h79, 16'h0013, 4'b0011, 5'd13, 1, 1, 0, 0};
    vecs[6]  = '{4'b1110, 7'h30, 16'h0013, 4'b0011, 5'd13, 1, 0, 0, 0};
    vecs[7]  = '{4'b1101, 7'h79, 16'h0013, 4'b0011, 5'd13, 1, 0, 0, 0};
    vecs[8]  = '{4'b1110, 7'h02, 16'h0013, 4'b0011, 5'd13, 1, 0, 0, 0};
    vecs[9]  = '{4'b1110, 7'h30, 16'h0013, 4'b0011, 5'd13, 1, 0, 0, 0};
    vecs[10] = '{4'b1110, 7'h02, 16'h0013, 4'b0011, 5'd13, 1, 0, 0, 0};
    vecs[11] = '{4'b1110, 7'h02, 16'h0016, 4'b0011, 5'd16, 1, 1, 0, 0};
    vecs[12] = '{4'b1100, 7'h30, 16'h0016, 4'b0011, 5'd16, 1, 0, 1, 0};
    vecs[13] = '{4'b1110, 7'h7E, 16'h0016, 4'b0011, 5'd16, 1, 0, 0, 1};
    vecs[14] = '{4'b1110, 7'h40, 16'h0016, 4'b0011, 5'd16, 1, 0, 0, 0};
    vecs[15] = '{4'b1110, 7'h40, 16'h0010, 4'b0011, 5'd10, 1, 1, 0, 0};
    vecs[16] = '{4'b1101, 7'h7F, 16'h0010, 4'b0011, 5'd10, 1, 0, 0, 0};
    vecs[17] = '{4'b1101, 7'h7F, 16'h00F0, 4'b0011, 5'd0,  1, 1, 0, 0};
    vecs[18] = '{4'b1110, 7'h78, 16'h00F0, 4'b0011, 5'd0,  1, 0, 0, 0};
    vecs[19] = '{4'b1110, 7'h78, 16'h00F7, 4'b0011, 5'd7,  1, 1, 0, 0};
    vecs[20] = '{4'b1101, 7'h24, 16'h00F7, 4'b0011, 5'd7,  1, 0, 0, 0};
    vecs[21] = '{4'b1101, 7'h24, 16'h0027, 4'b0011, 5'd0,  0, 1, 0, 0};
    vecs[22] = '{4'b1111, 7'h00, 16'h0027, 4'b0011, 5'd0,  0, 0, 0, 0};

    do_reset();
    chk_all(16'h0, 4'h0, 5'd0, 0, 0, 0, 0);
    $display("reset: digits=%h valid=%b", digits, digit_valid);

    foreach (vecs[i]) begin
      apply(vecs[i].an, vecs[i].seg, 1'b1);
      $display("vec %0d an=%b seg=%h -> digits=%h valid=%b num=%0d nv=%b upd=%b ea=%b es=%b",
               i, vecs[i].an, vecs[i].seg, digits, digit_valid, num_out, num_valid,
               update, err_an, err_seg);
      chk_all(vecs[i].dig, vecs[i].val, vecs[i].num, vecs[i].nv, vecs[i].upd, vecs[i].ea, vecs[i].es);
    end

    // Idle cycle with bus activity but no strobe: state holds, pulses low.
    apply(4'b1011, 7'h19, 1'b0);
    chk_all(16'h0027, 4'b0011, 5'd0, 0, 0, 0, 0);
    $display("idle: digits=%h", digits);

    // Reset between the two strobes needed to commit digit 2.
    apply(4'b1011, 7'h19, 1'b1);
    do_reset();
    chk_all(16'h0, 4'h0, 5'd0, 0, 0, 0, 0);
    apply(4'b1011, 7'h19, 1'b1);
    chk_all(16'h0, 4'h0, 5'd0, 0, 0, 0, 0);
    apply(4'b1011, 7'h19, 1'b1);
    chk_all(16'h0400, 4'b0100, 5'd0, 0, 1, 0, 0);
    $display("post-reset commit: digits=%h valid=%b", digits, digit_valid);

    // Randomized scans against the model.
    do_reset();
    m_dig = '0;
    m_val = '0;
    for (int k = 0; k < N; k++) hist[k].delete();
    for (int t = 0; t < 400; t++) begin
      en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        7:       a = 4'b1111;
        8, 9:    a = 4'($urandom);
        default: a = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pat[$urandom_range(0, 10)];
      model_step(a, s, en, u, ea, es);
      model_num(n, nv);
      apply(a, s, en);
      $display("rnd %0d en=%b an=%b seg=%h -> digits=%h valid=%b num=%0d upd=%b",
               t, en, a, s, digits, digit_valid, num_out, update);
      chk_all(m_dig, m_val, n, nv, u, ea, es);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
